imem_responder: RTL
===================

# imem_responder

Instruction-memory responder for the dual-issue fetch stage. It accepts a fetch PC and returns the instruction pair at PC and PC+4. It reads the pair as two word reads from a single-ported, wait-stated 32-bit instruction memory. While busy it holds `delay` high to stall fetch. It flags misaligned fetches (IADEE) and out-of-window fetches (IADFE) for the exception logic.

## Interface
Parameters:
- `BASE_ADDR`, 32'hbfc0_0000: first byte address of the instruction window.
- `WINDOW_BITS`, 16: window size is 2^WINDOW_BITS bytes.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  fetch request for `req_pc`; sampled only when `delay`=0.
- `req_pc`  in  32  fetch byte address.
- `req_flush`  in  1  abort any pending or in-flight fetch (branch/interrupt redirect).
- `delay`  out  1  busy; fetch must hold its PC.
- `resp_valid`  out  1  one-cycle pulse: `inst_0`/`inst_1`/error flags valid.
- `inst_0`  out  32  word at the requested PC.
- `inst_1`  out  32  word at PC+4.
- `IADEE`  out  1  address error: `req_pc[1:0]`≠0.
- `IADFE`  out  1  fetch fault: PC or PC+4 outside the window.
- `mem_rd`  out  1  memory read strobe.
- `mem_addr`  out  WINDOW_BITS  byte offset into the window, always word-aligned.
- `mem_rdata`  in  32  read data, valid when `mem_ready`=1.
- `mem_ready`  in  1  read beat complete this cycle.

## Operation
- States: IDLE, RD0, RD1, RESP, plus PF0 and PF1 when prefetch is enabled.
- IDLE/RESP with `req_valid`=1:
  - Misaligned: go to RESP; `IADEE`=1, both words 0, no memory access.
  - Else PC outside [BASE_ADDR, BASE_ADDR+2^WINDOW_BITS): go to RESP; `IADFE`=1, both words 0.
  - Else latch the PC and go to RD0.
- RD0: `mem_rd`=1, `mem_addr`=PC−BASE_ADDR. On `mem_ready`, capture word 0.
  - If PC+4 is still in the window, go to RD1.
  - Otherwise (last word of the window) go to RESP with `IADFE`=1 and `inst_1`=0.
- RD1: `mem_rd`=1, `mem_addr`=offset+4. On `mem_ready`, capture word 1 and go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle. Then go to IDLE, or accept a new request in the same cycle.
- Outputs hold between responses: `inst_0`, `inst_1`, `IADEE` and `IADFE` keep their values until the next RESP.
- `delay`=1 in RD0, RD1 and RESP-pending states; `delay`=0 in IDLE and RESP.
- `req_flush` in any state:
  - Go to IDLE next cycle and drop `mem_rd`. The memory tolerates abandoned reads.
  - No `resp_valid` for the aborted fetch; any late `mem_ready` is ignored.
  - Flush beats `req_valid` in the same cycle.
- Offset arithmetic is modulo 2^WINDOW_BITS. Window checks use full 32-bit compare with no wrap; PC=32'hffff_fffc gives IADFE.

## Timing
- Reset: state IDLE, `delay`=0, `resp_valid`=0, `inst_0`=`inst_1`=0, `IADEE`=`IADFE`=0, `mem_rd`=0, `mem_addr`=0. The prefetch buffer is invalid.
- Zero-wait memory: request in cycle 0, RD0 in cycle 1, RD1 in cycle 2, `resp_valid` in cycle 3. Each wait state adds one cycle.
- Error responses: `resp_valid` in cycle 1.
- Back-to-back: a request accepted in RESP enters RD0 the next cycle, giving a 3-cycle throughput per pair.
- Reset asserted mid-read: immediate return to reset values; the memory beat is abandoned.

## Configuration
- `IMEM_PREFETCH_EN` defined: after a good RESP with no new request and no flush, prefetch the pair at PC+8 via PF0/PF1 into a one-pair buffer, using the same window rules.
  - A PF fault marks the buffer invalid.
  - Request matching the valid buffer PC: RESP next cycle (latency 1).
  - Matching request while the prefetch is in flight: respond when the prefetch completes.
  - Mismatching request in PF: drop the prefetch and go to RD0 next cycle.
  - `req_flush` invalidates the buffer.
  - `delay`=0 during PF0/PF1.
- `IMEM_PREFETCH_EN` undefined: no PF states and no buffer; behaviour is exactly the base FSM.

## Test plan
- Reset, then request PC=32'hbfc0_0000 with zero wait, mem words 0x11111111/0x22222222 → `resp_valid` in cycle 3, `inst_0`=0x11111111, `inst_1`=0x22222222, flags 0.
- Request PC=32'hbfc0_0002 → `resp_valid` in cycle 1, `IADEE`=1, both words 0, `mem_rd` never high.
- Request PC=32'hbfc0_fffc → one read at offset 0xfffc, `IADFE`=1, `inst_1`=0; request 32'h8000_0000 → `IADFE`=1 with no read.
- Two wait states per beat, `req_flush` asserted in RD1 → no `resp_valid`; the next request returns correct data despite a late `mem_ready`.
- With `IMEM_PREFETCH_EN`: request 32'hbfc0_0000, idle until PF completes, request 32'hbfc0_0008 → `resp_valid` one cycle later with the PC+8/PC+12 words.
- With `IMEM_PREFETCH_EN`: request 32'hbfc0_0040 during PF0 → prefetch dropped, RD0 at offset 0x40, correct pair returned.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-pair fetch responder over a single-ported, wait-stated memory.
// Optional PC+8 prefetch buffer when IMEM_PREFETCH_EN is defined.
module imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'hbfc0_0000,
    parameter int          WINDOW_BITS = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [31:0]            req_pc,
    input  logic                   req_flush,
    output logic                   delay,
    output logic                   resp_valid,
    output logic [31:0]            inst_0,
    output logic [31:0]            inst_1,
    output logic                   IADEE,
    output logic                   IADFE,
    output logic                   mem_rd,
    output logic [WINDOW_BITS-1:0] mem_addr,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_ready
);

`ifdef IMEM_PREFETCH_EN
    typedef enum logic [2:0] {IDLE, RD0, RD1, RESP, PF0, PF1} state_t;
`else
    typedef enum logic [2:0] {IDLE, RD0, RD1, RESP} state_t;
`endif

    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'd1 << WINDOW_BITS);
    localparam logic [WINDOW_BITS-1:0] FOUR = 4;

    // 33-bit compare so addresses near 2^32 never wrap into the window
    function automatic logic in_win(input logic [32:0] a);
        return (a >= WIN_LO) && (a < WIN_HI);
    endfunction

    function automatic logic [WINDOW_BITS-1:0] off_of(input logic [31:0] a);
        return a[WINDOW_BITS-1:0] - BASE_ADDR[WINDOW_BITS-1:0];
    endfunction

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic [31:0] w0, w0_n;
    logic [31:0] i0_n, i1_n;
    logic        ee_n, fe_n;
    logic        busy, take, beat, req_mis, req_oow;

`ifdef IMEM_PREFETCH_EN
    logic [31:0] bpc, bpc_n, b0, b0_n, b1, b1_n;
    logic        bvalid, bv_n, pend, pend_n, pf_st, pf_hit, want;

    assign pf_st  = (state == PF0) || (state == PF1);
    assign busy   = (state == RD0) || (state == RD1) || pend;
    assign take   = req_valid && !busy && !req_flush;
    assign pf_hit = take && pf_st && (req_pc == bpc);
    assign want   = pend || pf_hit;
`else
    assign busy = (state == RD0) || (state == RD1);
    assign take = req_valid && !busy && !req_flush;
`endif

    assign delay   = busy;
    assign beat    = mem_ready && !req_flush;
    assign req_mis = (req_pc[1:0] != 2'b00);
    assign req_oow = !in_win({1'b0, req_pc});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pc     <= '0;
            w0     <= '0;
            inst_0 <= '0;
            inst_1 <= '0;
            IADEE  <= 1'b0;
            IADFE  <= 1'b0;
`ifdef IMEM_PREFETCH_EN
            bpc    <= '0;
            b0     <= '0;
            b1     <= '0;
            bvalid <= 1'b0;
            pend   <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            w0     <= w0_n;
            inst_0 <= i0_n;
            inst_1 <= i1_n;
            IADEE  <= ee_n;
            IADFE  <= fe_n;
`ifdef IMEM_PREFETCH_EN
            bpc    <= bpc_n;
            b0     <= b0_n;
            b1     <= b1_n;
            bvalid <= bv_n;
            pend   <= pend_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        w0_n       = w0;
        i0_n       = inst_0;
        i1_n       = inst_1;
        ee_n       = IADEE;
        fe_n       = IADFE;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        resp_valid = 1'b0;
`ifdef IMEM_PREFETCH_EN
        bpc_n  = bpc;
        b0_n   = b0;
        b1_n   = b1;
        bv_n   = bvalid;
        pend_n = 1'b0;
`endif

        unique case (state)
            IDLE: begin
            end
            RD0: begin
                mem_rd   = 1'b1;
                mem_addr = off_of(pc);
                if (beat) begin
                    if (in_win({1'b0, pc} + 33'd4)) begin
                        w0_n    = mem_rdata;
                        state_n = RD1;
                    end else begin
                        i0_n    = mem_rdata;
                        i1_n    = '0;
                        ee_n    = 1'b0;
                        fe_n    = 1'b1;
                        state_n = RESP;
                    end
                end
            end
            RD1: begin
                mem_rd   = 1'b1;
                mem_addr = off_of(pc) + FOUR;
                if (beat) begin
                    i0_n    = w0;
                    i1_n    = mem_rdata;
                    ee_n    = 1'b0;
                    fe_n    = 1'b0;
                    state_n = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                state_n    = IDLE;
`ifdef IMEM_PREFETCH_EN
                if (!req_valid && !req_flush && !IADEE && !IADFE &&
                    in_win({1'b0, pc} + 33'd8)) begin
                    bpc_n   = pc + 32'd8;
                    bv_n    = 1'b0;
                    state_n = PF0;
                end
`endif
            end
`ifdef IMEM_PREFETCH_EN
            PF0: begin
                mem_rd   = 1'b1;
                mem_addr = off_of(bpc);
                if (beat) begin
                    w0_n = mem_rdata;
                    if (in_win({1'b0, bpc} + 33'd4))
                        state_n = PF1;
                    else if (want)
                        state_n = RD0;
                    else
                        state_n = IDLE;
                end
            end
            PF1: begin
                mem_rd   = 1'b1;
                mem_addr = off_of(bpc) + FOUR;
                if (beat) begin
                    b0_n    = w0;
                    b1_n    = mem_rdata;
                    bv_n    = 1'b1;
                    state_n = IDLE;
                    if (want) begin
                        i0_n    = w0;
                        i1_n    = mem_rdata;
                        ee_n    = 1'b0;
                        fe_n    = 1'b0;
                        state_n = RESP;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase

        if (take) begin
            pc_n = req_pc;
            if (req_mis) begin
                i0_n    = '0;
                i1_n    = '0;
                ee_n    = 1'b1;
                fe_n    = 1'b0;
                state_n = RESP;
            end else if (req_oow) begin
                i0_n    = '0;
                i1_n    = '0;
                ee_n    = 1'b0;
                fe_n    = 1'b1;
                state_n = RESP;
`ifdef IMEM_PREFETCH_EN
            end else if (bvalid && (req_pc == bpc)) begin
                i0_n    = b0;
                i1_n    = b1;
                ee_n    = 1'b0;
                fe_n    = 1'b0;
                state_n = RESP;
            end else if (!pf_hit) begin
                state_n = RD0;
`else
            end else begin
                state_n = RD0;
`endif
            end
        end

        if (req_flush) begin
            state_n = IDLE;
`ifdef IMEM_PREFETCH_EN
            bv_n = 1'b0;
`endif
        end

`ifdef IMEM_PREFETCH_EN
        // a hit on the in-flight prefetch is remembered until PF1 lands
        pend_n = ((state_n == PF0) || (state_n == PF1)) && want;
`endif
    end

endmodule
